// File: rtl/audio_pkg.sv
// Shared audio datapath constants, delay-line FSM states and delay clamp helper.
// Pure definitions: no latency, no flow control.
package audio_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DLY_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A buffer of DEPTH entries can hold at most DEPTH-1 samples of delay.
    function automatic logic [ADDR_W-1:0] sat_delay(input logic [DLY_W-1:0] d);
        logic [ADDR_W-1:0] r;
        if (d > DLY_W'(DEPTH - 1)) begin
            r = ADDR_W'(DEPTH - 1);
        end else begin
            r = d[ADDR_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM inferable).
// Latency 1 clk on read, read data holds when rd_en is low; no backpressure.
module sdp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_dat_q;

    // No reset on the array or read register so the tools can map it to BSRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sample_delay_line.sv
// Sample-strobed delay line: each in_valid writes one sample and returns the one D strobes older.
// Latency exactly 1 clk from in_valid to out_valid; no backpressure, consumer takes every strobe.
module sample_delay_line
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DLY_W-1:0]  delay_num,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              filled
);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] d_lat_q, d_lat_d;
    logic [ADDR_W-1:0] d_new, raddr, fill_inc;
    state_t            state_q, state_d;
    logic              out_vld_q, out_vld_d;
    logic              sel_ram_q, sel_ram_d;
    logic [DATA_W-1:0] byp_dat_q, byp_dat_d;
    logic [DATA_W-1:0] ram_rd_dat;

    assign d_new    = sat_delay(delay_num);
    assign raddr    = wptr_q - d_lat_q;
    assign fill_inc = (fill_cnt_q == ADDR_W'(DEPTH - 1)) ? fill_cnt_q : fill_cnt_q + ADDR_W'(1);

    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_valid),
        .wr_addr (wptr_q),
        .wr_dat  (in_data),
        .rd_en   (in_valid),
        .rd_addr (raddr),
        .rd_dat  (ram_rd_dat)
    );

    always_comb begin
        wptr_d     = wptr_q;
        fill_cnt_d = fill_cnt_q;
        d_lat_d    = d_lat_q;
        state_d    = state_q;
        sel_ram_d  = sel_ram_q;
        byp_dat_d  = byp_dat_q;
        out_vld_d  = in_valid;

        if (in_valid) begin
            wptr_d = wptr_q + ADDR_W'(1);
            if (d_new != d_lat_q) begin
                // Delay change restarts the fill; a change to zero goes straight to bypass.
                d_lat_d    = d_new;
                fill_cnt_d = ADDR_W'(1);
                sel_ram_d  = 1'b0;
                if (d_new == '0) begin
                    state_d   = ST_RUN;
                    byp_dat_d = in_data;
                end else begin
                    state_d   = ST_FILL;
                    byp_dat_d = '0;
                end
            end else if (d_lat_q == '0) begin
                state_d    = ST_RUN;
                sel_ram_d  = 1'b0;
                byp_dat_d  = in_data;
                fill_cnt_d = fill_inc;
            end else if (state_q == ST_RUN || fill_cnt_q >= d_lat_q) begin
                state_d    = ST_RUN;
                sel_ram_d  = 1'b1;
                fill_cnt_d = fill_inc;
            end else begin
                sel_ram_d  = 1'b0;
                byp_dat_d  = '0;
                fill_cnt_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            d_lat_q    <= '0;
            state_q    <= ST_FILL;
            out_vld_q  <= 1'b0;
            sel_ram_q  <= 1'b0;
            byp_dat_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            fill_cnt_q <= fill_cnt_d;
            d_lat_q    <= d_lat_d;
            state_q    <= state_d;
            out_vld_q  <= out_vld_d;
            sel_ram_q  <= sel_ram_d;
            byp_dat_q  <= byp_dat_d;
        end
    end

    // RAM read register and bypass register both load on the strobe, so the mux output holds between strobes.
    assign out_valid = out_vld_q;
    assign out_data  = sel_ram_q ? ram_rd_dat : byp_dat_q;
    assign filled    = (state_q == ST_RUN);

endmodule

// File: tb/tb_sample_delay_line.sv
// Bench for sample_delay_line: queue-based sample history model, per-cycle compare, directed and random stimulus.
module tb_sample_delay_line;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [12:0] delay_num = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        filled;

    sample_delay_line dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .delay_num (delay_num),
        .out_valid (out_valid),
        .out_data  (out_data),
        .filled    (filled)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_vld = 1'b0;
    logic [15:0] exp_dat = '0;
    logic        exp_filled = 1'b0;
    bit          chk_en = 1'b0;

    // Model: every sample since reset, the delay in force, and strobes seen since that delay took effect.
    logic [15:0] hist[$];
    int          m_d = 0;
    int          m_n = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (out_valid !== exp_vld || out_data !== exp_dat || filled !== exp_filled) begin
                n_fail++;
                $display("FAIL cycle @%0t: got vld=%0b dat=%h filled=%0b, want vld=%0b dat=%h filled=%0b",
                         $time, out_valid, out_data, filled, exp_vld, exp_dat, exp_filled);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic model(input logic [15:0] d, input logic [12:0] dn,
                         output logic [15:0] o, output logic f);
        int dd;
        dd = (int'(dn) > 4095) ? 4095 : int'(dn);
        hist.push_back(d);
        if (dd != m_d) begin
            m_d = dd;
            m_n = 1;
        end else begin
            m_n++;
        end
        if (dd == 0) begin
            o = d;
            f = 1'b1;
        end else if (m_n > dd) begin
            o = hist[hist.size() - 1 - dd];
            f = 1'b1;
        end else begin
            o = '0;
            f = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with expectations updated.
    task automatic step(input bit v, input logic [15:0] d, input logic [12:0] dn);
        logic [15:0] nd;
        logic        nf;
        in_valid  = v;
        in_data   = d;
        delay_num = dn;
        nd = exp_dat;
        nf = exp_filled;
        if (v) model(d, dn, nd, nf);
        @(posedge clk);
        #1;
        exp_vld    = v;
        exp_dat    = nd;
        exp_filled = nf;
        in_valid   = 1'b0;
    endtask

    task automatic do_reset(input logic [12:0] dn);
        reset = 1'b1;
        #2;
        check("async_rst_vld", {31'd0, out_valid}, 32'd0);
        check("async_rst_dat", {16'd0, out_data}, 32'd0);
        check("async_rst_filled", {31'd0, filled}, 32'd0);
        hist.delete();
        m_d = 0;
        m_n = 0;
        exp_vld = 1'b0;
        exp_dat = '0;
        exp_filled = 1'b0;
        step(1'b0, 16'd0, dn);
        step(1'b0, 16'd0, dn);
        reset = 1'b0;
    endtask

    initial begin
        logic [12:0] dn_cur;
        logic [12:0] dn_drv;
        bit          v;

        #3;
        check("reset_vld", {31'd0, out_valid}, 32'd0);
        check("reset_dat", {16'd0, out_data}, 32'd0);
        check("reset_filled", {31'd0, filled}, 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Sanity: D=4, ramp strobed every third clock.
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 16'(i), 13'd4);
            check("sanity_vld", {31'd0, out_valid}, 32'd1);
            if (i == 1) check("sanity_first", {16'd0, out_data}, 32'd0);
            if (i == 4) check("sanity_fill4", {31'd0, filled}, 32'd0);
            if (i == 5) check("sanity_out5", {15'd0, filled, out_data}, {15'd0, 1'b1, 16'd1});
            if (i == 12) check("sanity_out12", {16'd0, out_data}, 32'd8);
            step(1'b0, 16'd0, 13'd4);
            check("sanity_idle_vld", {31'd0, out_valid}, 32'd0);
            step(1'b0, 16'd0, 13'd4);
        end

        // Bypass, back-to-back strobes.
        do_reset(13'd0);
        step(1'b1, 16'h1234, 13'd0);
        check("bypass_1", {15'd0, filled, out_data}, {15'd0, 1'b1, 16'h1234});
        step(1'b1, 16'h8000, 13'd0);
        check("bypass_2", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h8000});
        step(1'b0, 16'd0, 13'd0);

        // Delay change 10 -> 3 at sample 50.
        do_reset(13'd10);
        for (int i = 1; i <= 49; i++) step(1'b1, 16'(i), 13'd10);
        check("chg_pre", {15'd0, filled, out_data}, {15'd0, 1'b1, 16'd39});
        step(1'b1, 16'd50, 13'd3);
        check("chg_50", {15'd0, filled, out_data}, {15'd0, 1'b0, 16'd0});
        step(1'b1, 16'd51, 13'd3);
        step(1'b1, 16'd52, 13'd3);
        check("chg_52", {15'd0, filled, out_data}, {15'd0, 1'b0, 16'd0});
        step(1'b1, 16'd53, 13'd3);
        check("chg_53", {15'd0, filled, out_data}, {15'd0, 1'b1, 16'd50});
        step(1'b1, 16'd54, 13'd3);
        check("chg_54", {16'd0, out_data}, 32'd51);

        // Async reset mid-stream while out_valid is high, then refill with D=2.
        step(1'b1, 16'd55, 13'd3);
        check("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        do_reset(13'd2);
        step(1'b1, 16'd100, 13'd2);
        check("rst_refill_1", {16'd0, out_data}, 32'd0);
        step(1'b1, 16'd101, 13'd2);
        check("rst_refill_2", {15'd0, filled, out_data}, {15'd0, 1'b0, 16'd0});
        step(1'b1, 16'd102, 13'd2);
        check("rst_refill_3", {15'd0, filled, out_data}, {15'd0, 1'b1, 16'd100});

        // delay_num noise between strobes must not disturb the stream.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(200 + i), 13'd2);
            check("noise_dat", {15'd0, filled, out_data},
                  {15'd0, 1'b1, (i >= 2) ? 16'(198 + i) : 16'(101 + i)});
            step(1'b0, 16'd0, 13'($urandom_range(0, 8191)));
        end

        // Saturation and pointer wrap: 8191 clamps to 4095.
        do_reset(13'd8191);
        for (int i = 1; i <= 10000; i++) begin
            step(1'b1, 16'(i), 13'd8191);
            if (i == 4095) check("sat_4095", {15'd0, filled, out_data}, {15'd0, 1'b0, 16'd0});
            if (i == 4096) check("sat_4096", {15'd0, filled, out_data}, {15'd0, 1'b1, 16'd1});
            if (i == 10000) check("sat_10000", {16'd0, out_data}, 32'd5905);
        end

        // Random traffic with occasional delay changes, noise and resets.
        do_reset(13'd5);
        dn_cur = 13'd5;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 6))
                    0: dn_cur = 13'd0;
                    1: dn_cur = 13'd1;
                    2: dn_cur = 13'd2;
                    3: dn_cur = 13'd7;
                    4: dn_cur = 13'd64;
                    5: dn_cur = 13'd4095;
                    default: dn_cur = 13'($urandom_range(0, 8191));
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset(dn_cur);
            end
            v = ($urandom_range(0, 2) != 0);
            dn_drv = (!v && $urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 8191)) : dn_cur;
            step(v, 16'($urandom), dn_drv);
        end

        step(1'b0, 16'd0, dn_cur);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
